imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//   Writer side of the instruction-memory interface. The core only reads imem.
//   This block receives a framed byte stream from a UART receiver, assembles
//   little-endian 32-bit words, and writes them into imem. It holds the core in
//   reset until a complete program has been loaded.
// PARAMETERS
//   BASE_ADDR       32'h0000_0000  byte address of the first word written
//   MAX_WORDS       256            largest accepted word count (imem depth)
//   TIMEOUT_CYCLES  1000000        maximum idle cycles allowed between bytes inside a frame
// PORTS
//   clk            in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   rx_valid       in   1   one-cycle strobe: rx_data holds a new byte
//   rx_data        in   8   received byte
//   load_req       in   1   one-cycle pulse: restart loading after DONE or ERROR
//   imem_we        out  1   imem write strobe, one cycle per word
//   imem_addr      out  32  imem byte address (word aligned)
//   imem_wdata     out  32  word to write
//   cpu_hold       out  1   1 = keep the core's pc/regfile in reset
//   done           out  1   program loaded; core released
//   error          out  1   frame aborted (timeout or oversize count)
// BEHAVIOUR
//   - Clock and reset: one clock domain; reset is asynchronous and active-high.
//   - Reset values: state=LEN0, cpu_hold=1, done=0, error=0, imem_we=0, imem_addr=BASE_ADDR,
//     imem_wdata=0, byte and word counters=0, timeout counter=0.
//   - All outputs are registered. rx has no backpressure, so every rx_valid byte is consumed or dropped.
//   - Frame format: N[7:0], N[15:8], then N words of 4 bytes each, least significant byte first.
//   - States:
//     LEN0:  on rx_valid, latch N[7:0] -> LEN1.
//     LEN1:  on rx_valid, latch N[15:8].
//            N==0 -> DONE. N>MAX_WORDS -> ERROR. Otherwise -> DATA with word index=0.
//     DATA:  on rx_valid, shift the byte into position byte_cnt*8 and increment byte_cnt (mod 4).
//            On the 4th byte:
//              - the cycle after acceptance: imem_we=1 for exactly 1 cycle,
//                imem_addr=BASE_ADDR+4*index, imem_wdata=assembled word;
//              - index increments;
//              - if index+1==N -> DONE, entered in the same cycle imem_we is asserted.
//     DONE:  cpu_hold=0, done=1. rx bytes are ignored.
//            load_req -> LEN0 with cpu_hold=1, done=0, and counters cleared.
//     ERROR: cpu_hold=1, error=1.
//            rx_valid byte -> treated as N[7:0]; error clears; -> LEN1.
//            load_req -> LEN0.
//   - Timeout: applies in LEN1 and DATA.
//     - The counter clears on each accepted byte and increments otherwise.
//     - When it reaches TIMEOUT_CYCLES-1 with no byte -> ERROR.
//     - A partially assembled word is discarded and not written.
//     - LEN0 has no timeout.
//   - Simultaneous events:
//     - load_req together with rx_valid in DONE/ERROR: load_req wins and the byte is dropped.
//     - load_req in LEN0/LEN1/DATA: restarts at LEN0 and drops the in-flight word.
//     - A byte arriving on the same cycle the timeout fires: the byte wins and the counter clears.
//   - Address arithmetic: 32-bit. index is 16 bits. No wrap, because N<=MAX_WORDS.
//   - Reset mid-frame: all state returns to reset values immediately. No partial write is issued.
// TESTING
//   1. Stream 02 00 13 00 00 00 93 00 10 00 ->
//      we pulses twice: (0x0,0x00000013), then (0x4,0x00100093).
//      done=1 and cpu_hold=0 on the cycle after the 2nd write.
//   2. Stream 00 00 -> no writes; done=1 two cycles after the 2nd byte.
//   3. N=MAX_WORDS+1 (e.g. 01 01) -> error=1, cpu_hold=1, no writes.
//      A new frame 01 00 + 4 bytes then loads correctly.
//   4. N=1, send 3 bytes, then idle for TIMEOUT_CYCLES (use a small parameter, e.g. 16) ->
//      error=1, no write. Then a full frame recovers.
//   5. After DONE, pulse load_req on the same cycle as rx_valid ->
//      cpu_hold=1, state LEN0, byte dropped. The next frame writes from BASE_ADDR again.
//   6. Assert reset between the 2nd and 3rd data byte ->
//      outputs return to reset values, and the word is never written.

Source files
------------

// File: rtl/imem_loader_if.sv
// Loader-side bus bundle: the UART byte stream coming in and the imem write port going out.
// The master modport is the loader; the slave modport is the UART/imem environment around it.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed little-endian word stream from the UART,
// writes each word into imem and keeps the core in reset until the whole program is present.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 256,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus,
    input  logic          load_req,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]      MAX_N    = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state, state_n;
    logic [15:0]       len_q, len_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [15:0]       word_idx, word_idx_n;
    logic [31:0]       word_buf, word_buf_n;
    logic [TMO_W-1:0]  tmo_cnt, tmo_n;
    logic              we_q, we_n;
    logic [31:0]       addr_q, addr_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [15:0]       n_rx;

    // Full word count as it would be once the current byte is taken as N[15:8].
    assign n_rx = {bus.rx_data, len_q[7:0]};

    always_comb begin
        state_n    = state;
        len_n      = len_q;
        byte_cnt_n = byte_cnt;
        word_idx_n = word_idx;
        word_buf_n = word_buf;
        tmo_n      = '0;
        we_n       = 1'b0;
        addr_n     = addr_q;
        wdata_n    = wdata_q;

        // load_req outranks any byte in every state; restart discards whatever was in flight.
        if (load_req) begin
            state_n    = S_LEN0;
            len_n      = '0;
            byte_cnt_n = '0;
            word_idx_n = '0;
            word_buf_n = '0;
        end else begin
            case (state)
                S_LEN0: begin
                    if (bus.rx_valid) begin
                        len_n   = {8'h00, bus.rx_data};
                        state_n = S_LEN1;
                    end
                end

                S_LEN1: begin
                    if (bus.rx_valid) begin
                        len_n      = n_rx;
                        byte_cnt_n = '0;
                        word_idx_n = '0;
                        word_buf_n = '0;
                        if (n_rx == 16'h0000)
                            state_n = S_DONE;
                        else if ({1'b0, n_rx} > MAX_N)
                            state_n = S_ERROR;
                        else
                            state_n = S_DATA;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_n = S_ERROR;
                    end else begin
                        tmo_n = tmo_cnt + TMO_W'(1);
                    end
                end

                S_DATA: begin
                    if (bus.rx_valid) begin
                        byte_cnt_n = byte_cnt + 2'd1;
                        word_buf_n[{byte_cnt, 3'b000} +: 8] = bus.rx_data;
                        if (byte_cnt == 2'd3) begin
                            we_n       = 1'b1;
                            addr_n     = BASE_ADDR + {14'd0, word_idx, 2'b00};
                            wdata_n    = {bus.rx_data, word_buf[23:0]};
                            word_idx_n = word_idx + 16'd1;
                            word_buf_n = '0;
                            if ((word_idx + 16'd1) == len_q)
                                state_n = S_DONE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // The partial word is dropped; nothing reaches imem.
                        state_n    = S_ERROR;
                        byte_cnt_n = '0;
                        word_buf_n = '0;
                    end else begin
                        tmo_n = tmo_cnt + TMO_W'(1);
                    end
                end

                S_DONE: begin
                    state_n = S_DONE;
                end

                S_ERROR: begin
                    if (bus.rx_valid) begin
                        len_n      = {8'h00, bus.rx_data};
                        byte_cnt_n = '0;
                        word_idx_n = '0;
                        word_buf_n = '0;
                        state_n    = S_LEN1;
                    end
                end

                default: begin
                    state_n = S_LEN0;
                end
            endcase
        end
    end

    // Status flags follow the state register, so they trail a state change by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_LEN0;
            len_q    <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            word_buf <= '0;
            tmo_cnt  <= '0;
            we_q     <= 1'b0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_n;
            len_q    <= len_n;
            byte_cnt <= byte_cnt_n;
            word_idx <= word_idx_n;
            word_buf <= word_buf_n;
            tmo_cnt  <= tmo_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            cpu_hold <= (state != S_DONE);
            done     <= (state == S_DONE);
            error    <= (state == S_ERROR);
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

endmodule
